// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per cycle, NR selectable (10/12/14).
// Round keys are fetched combinationally from an external store indexed by SelKey.
module aes_inv_cipher_iter #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          In_Valid,
    output logic          In_Ry,
    input  logic [127:0]  CT,
    output logic [KW-1:0] SelKey,
    input  logic [127:0]  Key,
    output logic          Out_Valid,
    input  logic          Out_Ry,
    output logic [127:0]  PT,
    output logic          Busy
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
        if ((2 ** KW) <= NR) begin : g_bad_kw
            $error("aes_inv_cipher_iter: KW too narrow to index NR");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StRound, StLast, StHold} state_e;

    state_e         r_fsm;
    state_e         w_fsm_nxt;
    logic [127:0]   r_blk;
    logic [127:0]   r_pt;
    logic [KW-1:0]  r_rnd;
    logic [127:0]   w_isr;
    logic [127:0]   w_isb;
    logic [127:0]   w_ark;
    logic [127:0]   w_imc;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] a;
        a = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(r+4*c) -: 8];
                x2[r] = xtime(a[r]);
                x4[r] = xtime(x2[r]);
                x8[r] = xtime(x4[r]);
                m9[r] = x8[r] ^ a[r];
                mb[r] = x8[r] ^ x2[r] ^ a[r];
                md[r] = x8[r] ^ x4[r] ^ a[r];
                me[r] = x8[r] ^ x4[r] ^ x2[r];
            end
            o[127-8*(4*c)   -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    always_comb begin
        w_isr = inv_shift_rows(r_blk);
        w_isb = inv_sub_bytes(w_isr);
        w_ark = w_isb ^ Key;
        w_imc = inv_mix_columns(w_ark);
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        In_Ry     = 1'b0;
        Out_Valid = 1'b0;
        Busy      = 1'b0;
        SelKey    = KW'(NR);
        unique case (r_fsm)
            StIdle: begin
                In_Ry = 1'b1;
                if (In_Valid) w_fsm_nxt = StRound;
            end
            StRound: begin
                Busy   = 1'b1;
                SelKey = r_rnd;
                if (r_rnd == KW'(1)) w_fsm_nxt = StLast;
            end
            StLast: begin
                Busy      = 1'b1;
                SelKey    = '0;
                w_fsm_nxt = StHold;
            end
            StHold: begin
                Out_Valid = 1'b1;
                if (Out_Ry) w_fsm_nxt = StIdle;
            end
            default: w_fsm_nxt = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_fsm <= StIdle;
            r_blk <= '0;
            r_pt  <= '0;
            r_rnd <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            case (r_fsm)
                StIdle: begin
                    if (In_Valid) begin
                        r_blk <= CT ^ Key;
                        r_rnd <= KW'(NR - 1);
                    end
                end
                StRound: begin
                    r_blk <= w_imc;
                    r_rnd <= r_rnd - KW'(1);
                end
                StLast:  r_pt <= w_ark;
                default: ;
            endcase
        end
    end

    assign PT = r_pt;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors plus random blocks checked
// against a forward-cipher reference (random PT -> CT -> expect PT back).
module tb_aes_inv_cipher_iter;

    localparam int NR = 10;
    localparam logic [127:0] PT_REF = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_SEQ =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv, iry, ov, ory, busy;
    logic [127:0] ct, key, pt;
    logic [3:0] sk;
    logic iv12, iry12, ov12, busy12, iv14, iry14, ov14, busy14, ory_x;
    logic [127:0] key12, key14, pt12, pt14;
    logic [3:0] sk12, sk14;

    logic [127:0] rk10 [16];
    logic [127:0] rk12 [16];
    logic [127:0] rk14 [16];
    logic [127:0] rk_tmp [16];
    logic [7:0]   sbox [256];
    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign key   = rk10[sk];
    assign key12 = rk12[sk12];
    assign key14 = rk14[sk14];

    aes_inv_cipher_iter #(.NR(10), .KW(4)) u10 (
        .Clk(clk), .Rst(rst), .In_Valid(iv), .In_Ry(iry), .CT(ct), .SelKey(sk), .Key(key),
        .Out_Valid(ov), .Out_Ry(ory), .PT(pt), .Busy(busy)
    );
    aes_inv_cipher_iter #(.NR(12), .KW(4)) u12 (
        .Clk(clk), .Rst(rst), .In_Valid(iv12), .In_Ry(iry12), .CT(CT_C2), .SelKey(sk12),
        .Key(key12), .Out_Valid(ov12), .Out_Ry(ory_x), .PT(pt12), .Busy(busy12)
    );
    aes_inv_cipher_iter #(.NR(14), .KW(4)) u14 (
        .Clk(clk), .Rst(rst), .In_Valid(iv14), .In_Ry(iry14), .CT(CT_C3), .SelKey(sk14),
        .Key(key14), .Out_Valid(ov14), .Out_Ry(ory_x), .PT(pt14), .Busy(busy14)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic key_expand(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 16; j++)
            rk_tmp[j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
    endtask

    // Forward AES-128 with the rk10 schedule.
    function automatic logic [127:0] aes_enc(input logic [127:0] p);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] s = p ^ rk10[0];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
            b = t;
            if (rnd < NR) begin
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    b[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s = s ^ rk10[rnd];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic accept_blk(input logic [127:0] c);
        iv = 1'b1;
        ct = c;
        n_total++;
        if (iry !== 1'b1 || sk !== 4'(NR)) begin
            n_bad++;
            $display("FAIL accept_idle: in_ry=%b selkey=%0d want 1/%0d", iry, sk, NR);
        end
        @(posedge clk); #1;
        iv = 1'b0;
        ct = rnd128();
    endtask

    task automatic track_blk(input logic [127:0] exp_pt, input bit noise);
        for (int c = 1; c <= NR; c++) begin
            n_total++;
            if ({busy, iry, ov, sk} !== {1'b1, 1'b0, 1'b0, 4'(NR - c)}) begin
                n_bad++;
                $display("FAIL round_%0d: busy/in_ry/out_valid/selkey=%b%b%b/%0d want 100/%0d",
                         c, busy, iry, ov, sk, NR - c);
            end
            if (noise) begin
                iv  = 1'($urandom);
                ory = 1'($urandom);
                ct  = rnd128();
            end
            @(posedge clk); #1;
        end
        iv  = 1'b0;
        ory = 1'b0;
        n_total++;
        if (ov !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL latency: out_valid=%b busy=%b want 1/0 after %0d edges", ov, busy, NR);
        end
        n_total++;
        if (pt !== exp_pt) begin
            n_bad++;
            $display("FAIL pt: got %h want %h", pt, exp_pt);
        end
    endtask

    task automatic consume();
        ory = 1'b1;
        @(posedge clk); #1;
        ory = 1'b0;
        n_total++;
        if (ov !== 1'b0 || iry !== 1'b1 || sk !== 4'(NR)) begin
            n_bad++;
            $display("FAIL consume: out_valid=%b in_ry=%b selkey=%0d want 0/1/%0d", ov, iry, sk, NR);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; ory = 1'b0; ct = '0;
        iv12 = 1'b0; iv14 = 1'b0; ory_x = 1'b0;
        #12;
        n_total++;
        if ({iry, ov, busy, sk} !== {1'b1, 1'b0, 1'b0, 4'(NR)}) begin
            n_bad++;
            $display("FAIL reset_ctl: in_ry/out_valid/busy/selkey=%b%b%b/%0d want 100/%0d",
                     iry, ov, busy, sk, NR);
        end
        n_total++;
        if (pt !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_pt: got %h want 0", pt);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips128();
        accept_blk(CT_C1);
        track_blk(PT_REF, 1'b0);
        consume();
    endtask

    task automatic test_noise();
        accept_blk(CT_C1);
        track_blk(PT_REF, 1'b1);
        consume();
        for (int i = 0; i < 3; i++) begin
            ory = 1'b1;
            @(posedge clk); #1;
            n_total++;
            if (ov !== 1'b0 || iry !== 1'b1) begin
                n_bad++;
                $display("FAIL noise_idle: out_valid=%b in_ry=%b want 0/1", ov, iry);
            end
        end
        ory = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] p2 = rnd128();
        logic [127:0] c2 = aes_enc(p2);
        accept_blk(CT_C1);
        track_blk(PT_REF, 1'b0);
        iv = 1'b1;
        ct = c2;
        for (int i = 0; i < 20; i++) begin
            n_total++;
            if ({ov, iry, pt} !== {1'b1, 1'b0, PT_REF}) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ry=%b pt=%h want 1/0/%h",
                         i, ov, iry, pt, PT_REF);
            end
            @(posedge clk); #1;
        end
        ory = 1'b1;
        @(posedge clk); #1;
        ory = 1'b0;
        n_total++;
        if (iry !== 1'b1 || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: in_ry=%b out_valid=%b want 1/0", iry, ov);
        end
        @(posedge clk); #1;
        iv = 1'b0;
        ct = rnd128();
        track_blk(p2, 1'b0);
        consume();
    endtask

    task automatic test_back_to_back();
        int acc_t[$];
        int nout = 0;
        bit drop;
        iv = 1'b1; ory = 1'b1; ct = CT_C1;
        for (int t = 0; t < 3 * (NR + 2) + 4; t++) begin
            drop = 1'b0;
            if (iv && iry) begin
                acc_t.push_back(t);
                drop = (acc_t.size() == 3);
            end
            if (ov) begin
                nout++;
                n_total++;
                if (pt !== PT_REF) begin
                    n_bad++;
                    $display("FAIL stream_pt_%0d: got %h want %h", nout, pt, PT_REF);
                end
            end
            @(posedge clk); #1;
            if (drop) iv = 1'b0;
        end
        ory = 1'b0;
        n_total++;
        if (acc_t.size() != 3 || nout != 3) begin
            n_bad++;
            $display("FAIL stream_count: accepts=%0d outputs=%0d want 3/3", acc_t.size(), nout);
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            n_total++;
            if (acc_t[i] - acc_t[i-1] != NR + 2) begin
                n_bad++;
                $display("FAIL stream_gap_%0d: got %0d want %0d", i, acc_t[i] - acc_t[i-1],
                         NR + 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        accept_blk(CT_C1);
        repeat (4) @(posedge clk);
        #1;
        n_total++;
        if (sk !== 4'd5) begin
            n_bad++;
            $display("FAIL rst_mid_round: selkey=%0d want 5", sk);
        end
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({iry, ov, busy, sk, pt} !== {1'b1, 1'b0, 1'b0, 4'(NR), 128'h0}) begin
            n_bad++;
            $display("FAIL rst_mid: in_ry/out_valid/busy/selkey=%b%b%b/%0d pt=%h want 100/%0d 0",
                     iry, ov, busy, sk, pt, NR);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        accept_blk(CT_C1);
        track_blk(PT_REF, 1'b0);
        consume();
    endtask

    task automatic test_random();
        logic [127:0] p;
        for (int n = 0; n < 6; n++) begin
            key_expand({rnd128(), 128'h0}, 4);
            rk10 = rk_tmp;
            p = rnd128();
            accept_blk(aes_enc(p));
            track_blk(p, 1'(n % 2));
            consume();
        end
    endtask

    task automatic test_aes192_256();
        int lat12 = -1;
        int lat14 = -1;
        logic [127:0] p12 = '0;
        logic [127:0] p14 = '0;
        iv12 = 1'b1; iv14 = 1'b1;
        n_total++;
        if (iry12 !== 1'b1 || iry14 !== 1'b1) begin
            n_bad++;
            $display("FAIL wide_idle: in_ry12=%b in_ry14=%b want 1/1", iry12, iry14);
        end
        @(posedge clk); #1;
        iv12 = 1'b0; iv14 = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (ov12 && lat12 < 0) begin lat12 = t; p12 = pt12; end
            if (ov14 && lat14 < 0) begin lat14 = t; p14 = pt14; end
        end
        n_total++;
        if (lat12 != 12 || p12 !== PT_REF) begin
            n_bad++;
            $display("FAIL aes192: latency=%0d pt=%h want 12/%h", lat12, p12, PT_REF);
        end
        n_total++;
        if (lat14 != 14 || p14 !== PT_REF) begin
            n_bad++;
            $display("FAIL aes256: latency=%0d pt=%h want 14/%h", lat14, p14, PT_REF);
        end
        ory_x = 1'b1;
        @(posedge clk); #1;
        ory_x = 1'b0;
    endtask

    initial begin
        build_sbox();
        key_expand(KEY_SEQ, 6);
        rk12 = rk_tmp;
        key_expand(KEY_SEQ, 8);
        rk14 = rk_tmp;
        key_expand({KEY_SEQ[255:128], 128'h0}, 4);
        rk10 = rk_tmp;
        test_reset();
        test_fips128();
        test_noise();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_aes192_256();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
